// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution accelerator host DMA and core.
//   - DSIZE_DEFAULT : byte capacity of the accelerator DI/DO memories
//   - WORD_SHIFT    : shift converting a 32-bit word index to a byte address
//   - state_e       : host DMA sequencing states
// No ports (package).
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DSIZE_DEFAULT = 256;
    localparam int WORD_SHIFT    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/conv_dma_skid.sv
// ---------------------------------------------------------------------------
// conv_dma_skid
// One-entry output register for the host DMA read-back stream. A word loaded
// here is held stable until the downstream consumer takes it.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : capture data_i/last_i into the register this cycle
//   data_i        : word to capture (accelerator output memory data)
//   last_i        : final-word marker to capture alongside data_i
//   ready_i       : downstream ready
//   data_o        : registered output word
//   valid_o       : registered output valid
//   last_o        : registered final-word marker
// ---------------------------------------------------------------------------
module conv_dma_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        last_i,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        last_o
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    // A new load always wins; the owner only loads when the slot is empty
    // or being emptied this cycle, so no word is ever overwritten unseen.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/conv_host_dma.sv
// ---------------------------------------------------------------------------
// conv_host_dma
// Host-side initiator for the convolution accelerator. Loads an input image
// from a 32-bit valid/ready stream into the accelerator input memory, pulses
// start, waits for done, then streams the output memory back out with a last
// marker.
// Optional build macro: CONV_TIMEOUT_EN enables a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles that sets the sticky err flag and ends the job.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   cmd_go                       : one-cycle job request (IDLE only)
//   cfg_in_words, cfg_out_words  : words to load / read back (clipped)
//   s_data, s_valid, s_ready     : input image stream
//   mi_addr, mi_data, mi_wr      : accelerator input memory write port
//   start, done                  : accelerator start pulse / completion
//   mo_addr, mo_data             : accelerator output memory read port
//   m_data, m_valid, m_ready,
//   m_last                       : output result stream
//   busy, job_done, err          : status
// ---------------------------------------------------------------------------
module conv_host_dma
    import conv_pkg::*;
#(
    parameter int DSIZE          = DSIZE_DEFAULT,
    parameter int AW             = $clog2(DSIZE),
    parameter int CW             = $clog2(DSIZE) - 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_go,
    input  logic [CW-1:0] cfg_in_words,
    input  logic [CW-1:0] cfg_out_words,
    input  logic [31:0]   s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [AW-1:0] mi_addr,
    output logic [31:0]   mi_data,
    output logic          mi_wr,
    output logic          start,
    input  logic          done,
    output logic [AW-1:0] mo_addr,
    input  logic [31:0]   mo_data,
    output logic [31:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          job_done,
    output logic          err
);

    localparam logic [CW-1:0] MAX_WORDS = CW'(DSIZE / 4);

    function automatic logic [CW-1:0] clipWords(input logic [CW-1:0] w);
        return (w > MAX_WORDS) ? MAX_WORDS : w;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] inWords_q, inWords_d;
    logic [CW-1:0] outWords_q, outWords_d;
    logic [CW-1:0] wrIdx_q, wrIdx_d;
    logic [CW-1:0] rdIdx_q, rdIdx_d;
    logic          miWr_q, miWr_d;
    logic [AW-1:0] miAddr_q, miAddr_d;
    logic [31:0]   miData_q, miData_d;
    logic          jobDone_q, jobDone_d;

    logic          issue;
    logic          issueLast;
    logic          finalHs;
    logic [CW-1:0] inClip;
    logic [CW-1:0] outClip;

`ifdef CONV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmoCnt_q, tmoCnt_d;
    logic          err_q, err_d;
`endif

    assign inClip  = clipWords(cfg_in_words);
    assign outClip = clipWords(cfg_out_words);

    // The last word leaving the output register ends the job.
    assign finalHs = m_valid && m_ready && m_last;

    // Sequencing, counters and write-port next state. The write port is
    // registered so each accepted beat appears on mi_* one cycle later,
    // which makes the final write coincide with the start pulse in KICK.
    always_comb begin
        state_d    = state_q;
        inWords_d  = inWords_q;
        outWords_d = outWords_q;
        wrIdx_d    = wrIdx_q;
        rdIdx_d    = rdIdx_q;
        miWr_d     = 1'b0;
        miAddr_d   = miAddr_q;
        miData_d   = miData_q;
        jobDone_d  = 1'b0;
        issue      = 1'b0;
        issueLast  = 1'b0;
`ifdef CONV_TIMEOUT_EN
        tmoCnt_d   = tmoCnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_go) begin
                    inWords_d  = inClip;
                    outWords_d = outClip;
                    wrIdx_d    = '0;
                    rdIdx_d    = '0;
`ifdef CONV_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = (inClip == '0) ? KICK : LOAD;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    miWr_d   = 1'b1;
                    miData_d = s_data;
                    miAddr_d = AW'(wrIdx_q) << WORD_SHIFT;
                    wrIdx_d  = wrIdx_q + CW'(1);
                    if (wrIdx_q == inWords_q - CW'(1)) begin
                        state_d = KICK;
                    end
                end
            end
            KICK: begin
`ifdef CONV_TIMEOUT_EN
                tmoCnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    if (outWords_q == '0) begin
                        jobDone_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
`ifdef CONV_TIMEOUT_EN
                else if (tmoCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d     = 1'b1;
                    jobDone_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + TW'(1);
                end
`endif
            end
            DRAIN: begin
                // Refill the output register whenever it is empty or being
                // emptied, giving one word per cycle under continuous ready.
                if ((!m_valid || m_ready) && (rdIdx_q != outWords_q)) begin
                    issue     = 1'b1;
                    issueLast = (rdIdx_q == outWords_q - CW'(1));
                    rdIdx_d   = rdIdx_q + CW'(1);
                end
                if (finalHs) begin
                    jobDone_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inWords_q  <= '0;
            outWords_q <= '0;
            wrIdx_q    <= '0;
            rdIdx_q    <= '0;
            miWr_q     <= 1'b0;
            miAddr_q   <= '0;
            miData_q   <= '0;
            jobDone_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inWords_q  <= inWords_d;
            outWords_q <= outWords_d;
            wrIdx_q    <= wrIdx_d;
            rdIdx_q    <= rdIdx_d;
            miWr_q     <= miWr_d;
            miAddr_q   <= miAddr_d;
            miData_q   <= miData_d;
            jobDone_q  <= jobDone_d;
        end
    end

`ifdef CONV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmoCnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tmoCnt_q <= tmoCnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    conv_dma_skid uSkid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (issue),
        .data_i  (mo_data),
        .last_i  (issueLast),
        .ready_i (m_ready),
        .data_o  (m_data),
        .valid_o (m_valid),
        .last_o  (m_last)
    );

    assign s_ready  = (state_q == LOAD);
    assign start    = (state_q == KICK);
    assign busy     = (state_q != IDLE);
    assign mi_wr    = miWr_q;
    assign mi_addr  = miAddr_q;
    assign mi_data  = miData_q;
    assign mo_addr  = AW'(rdIdx_q) << WORD_SHIFT;
    assign job_done = jobDone_q;

endmodule

// File: tb/tb_conv_host_dma.sv
// ---------------------------------------------------------------------------
// tb_conv_host_dma
// Directed bench for conv_host_dma. Expected memory writes and expected
// output words are queued when stimulus is driven; a monitor pops and
// compares them as the DUT produces them. The accelerator output memory is
// modelled as mo_data = mo_addr + 0xA0.
// Build with CONV_TIMEOUT_EN to also exercise the WAIT watchdog (16 cycles).
// ---------------------------------------------------------------------------
module tb_conv_host_dma;

    localparam int DSIZE = 256;
    localparam int AW    = 8;
    localparam int CW    = 7;
`ifdef CONV_TIMEOUT_EN
    localparam int TMO   = 16;
`else
    localparam int TMO   = 65535;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } miExp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } outExp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_go;
    logic [CW-1:0] cfg_in_words;
    logic [CW-1:0] cfg_out_words;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] mi_addr;
    logic [31:0]   mi_data;
    logic          mi_wr;
    logic          start;
    logic          done;
    logic [AW-1:0] mo_addr;
    logic [31:0]   mo_data;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          job_done;
    logic          err;

    int testsRun     = 0;
    int failCount    = 0;
    int startCount   = 0;
    int jobDoneCount = 0;

    miExp_t  miQ[$];
    outExp_t outQ[$];

    always #5 clk = ~clk;

    assign mo_data = 32'h0000_00A0 + {24'h0, mo_addr};

    conv_host_dma #(
        .DSIZE          (DSIZE),
        .AW             (AW),
        .CW             (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_go        (cmd_go),
        .cfg_in_words  (cfg_in_words),
        .cfg_out_words (cfg_out_words),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .mi_addr       (mi_addr),
        .mi_data       (mi_data),
        .mi_wr         (mi_wr),
        .start         (start),
        .done          (done),
        .mo_addr       (mo_addr),
        .mo_data       (mo_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .job_done      (job_done),
        .err           (err)
    );

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs read 1 unit after the
    // falling edge, well away from the rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CW-1:0] inW, input logic [CW-1:0] outW);
        cmd_go        = 1'b1;
        cfg_in_words  = inW;
        cfg_out_words = outW;
        tick();
        cmd_go        = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        int guard;
        s_valid = 1'b1;
        s_data  = w;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!s_ready) checkOutput("s_ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic waitLastHandshake(input string tag);
        int guard;
        guard = 0;
        while (!(m_valid && m_ready && m_last) && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_last_hs"}, 32'(m_valid && m_ready && m_last), 32'd1);
        tick();
        checkOutput({tag, "_job_done"}, 32'(job_done), 32'd1);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: samples 3 units after the falling edge, after the
    // main sequence has driven the inputs for the coming rising edge.
    always begin
        @(negedge clk);
        #3;
        if (rst_n === 1'b1) begin
            if (mi_wr === 1'b1 || mi_wr === 1'bx) begin
                if (miQ.size() == 0) begin
                    checkOutput("mi_unexpected", 32'(mi_wr), 32'd0);
                end else begin
                    miExp_t e;
                    e = miQ.pop_front();
                    checkOutput("mi_addr", 32'(mi_addr), 32'(e.addr));
                    checkOutput("mi_data", mi_data, e.data);
                end
            end
            if (m_valid !== 1'b0) begin
                if (outQ.size() == 0) begin
                    checkOutput("m_unexpected", 32'(m_valid), 32'd0);
                end else begin
                    checkOutput("m_data", m_data, outQ[0].data);
                    checkOutput("m_last", 32'(m_last), 32'(outQ[0].last));
                    if (m_ready) void'(outQ.pop_front());
                end
            end
            if (start === 1'b1) startCount++;
            if (job_done === 1'b1) jobDoneCount++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] img [4];
        logic        pat [5];
        int          expStarts;
        int          expDones;

        img[0] = 32'h0403_0201;
        img[1] = 32'h0807_0605;
        img[2] = 32'h0C0B_0A09;
        img[3] = 32'h100F_0E0D;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        expStarts = 0;
        expDones  = 0;

        rst_n         = 1'b0;
        cmd_go        = 1'b0;
        cfg_in_words  = '0;
        cfg_out_words = '0;
        s_data        = '0;
        s_valid       = 1'b0;
        done          = 1'b0;
        m_ready       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_mi_wr",    32'(mi_wr),    32'd0);
        checkOutput("rst_mi_addr",  32'(mi_addr),  32'd0);
        checkOutput("rst_mi_data",  mi_data,       32'd0);
        checkOutput("rst_start",    32'(start),    32'd0);
        checkOutput("rst_s_ready",  32'(s_ready),  32'd0);
        checkOutput("rst_m_valid",  32'(m_valid),  32'd0);
        checkOutput("rst_m_last",   32'(m_last),   32'd0);
        checkOutput("rst_m_data",   m_data,        32'd0);
        checkOutput("rst_mo_addr",  32'(mo_addr),  32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_job_done", 32'(job_done), 32'd0);
        checkOutput("rst_err",      32'(err),      32'd0);
        rst_n = 1'b1;
        tick();

        // Basic load of 4 words, then drain 3 words with backpressure; a
        // cmd_go issued during DRAIN must be ignored.
        $display("[TB] basic job with backpressured drain");
        for (int i = 0; i < 4; i++) miQ.push_back('{addr: AW'(i * 4), data: img[i]});
        for (int i = 0; i < 3; i++) outQ.push_back('{data: 32'hA0 + 32'(i * 4), last: (i == 2)});
        applyStimulus(7'd4, 7'd3);
        checkOutput("job1_busy_load", 32'(busy), 32'd1);
        checkOutput("job1_s_ready",   32'(s_ready), 32'd1);
        for (int i = 0; i < 4; i++) sendWord(img[i]);
        checkOutput("job1_start_kick",   32'(start),   32'd1);
        checkOutput("job1_s_ready_kick", 32'(s_ready), 32'd0);
        checkOutput("job1_mi_wr_kick",   32'(mi_wr),   32'd1);
        done = 1'b1;
        tick();
        checkOutput("job1_start_once", 32'(start), 32'd0);
        checkOutput("job1_busy_wait",  32'(busy),  32'd1);
        tick();
        done = 1'b0;
        checkOutput("job1_drain_empty", 32'(m_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            m_ready = pat[k];
            cmd_go  = (k == 1);
            if (k == 1) cfg_in_words = 7'd5;
            tick();
        end
        cmd_go  = 1'b0;
        m_ready = 1'b1;
        waitLastHandshake("job1");
        expStarts++;
        expDones++;
        tick();
        checkOutput("job1_job_done_pulse", 32'(job_done), 32'd0);
        checkOutput("job1_m_valid_idle",   32'(m_valid),  32'd0);

        // Zero counts: straight to KICK, job_done right after done, no data.
        $display("[TB] zero-count job");
        m_ready = 1'b0;
        applyStimulus(7'd0, 7'd0);
        checkOutput("zero_start", 32'(start), 32'd1);
        checkOutput("zero_mi_wr", 32'(mi_wr), 32'd0);
        done = 1'b1;
        tick();
        checkOutput("zero_start_off",    32'(start),    32'd0);
        checkOutput("zero_no_done_yet",  32'(job_done), 32'd0);
        tick();
        done = 1'b0;
        checkOutput("zero_job_done", 32'(job_done), 32'd1);
        checkOutput("zero_busy",     32'(busy),     32'd0);
        checkOutput("zero_m_valid",  32'(m_valid),  32'd0);
        expStarts++;
        expDones++;
        tick();

        // Reset in the middle of an 8-word load.
        $display("[TB] reset during load");
        miQ.push_back('{addr: 8'd0, data: 32'h1111_0000});
        miQ.push_back('{addr: 8'd4, data: 32'h1111_0001});
        applyStimulus(7'd8, 7'd1);
        sendWord(32'h1111_0000);
        sendWord(32'h1111_0001);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_mi_wr",    32'(mi_wr),   32'd0);
        checkOutput("midrst_mi_addr",  32'(mi_addr), 32'd0);
        checkOutput("midrst_mi_data",  mi_data,      32'd0);
        checkOutput("midrst_s_ready",  32'(s_ready), 32'd0);
        checkOutput("midrst_busy",     32'(busy),    32'd0);
        checkOutput("midrst_start",    32'(start),   32'd0);
        miQ.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh job after reset must begin at address 0.
        $display("[TB] job after reset");
        miQ.push_back('{addr: 8'd0, data: 32'h2222_0000});
        miQ.push_back('{addr: 8'd4, data: 32'h2222_0001});
        outQ.push_back('{data: 32'hA0, last: 1'b1});
        applyStimulus(7'd2, 7'd1);
        sendWord(32'h2222_0000);
        sendWord(32'h2222_0001);
        checkOutput("post_start", 32'(start), 32'd1);
        done    = 1'b1;
        m_ready = 1'b1;
        tick();
        tick();
        done = 1'b0;
        waitLastHandshake("post");
        expStarts++;
        expDones++;
        tick();

        // Oversized read-back count is clipped to 64 words; full throughput.
        $display("[TB] clipped full-throughput drain");
        for (int i = 0; i < 64; i++) outQ.push_back('{data: 32'hA0 + 32'(i * 4), last: (i == 63)});
        applyStimulus(7'd0, 7'd70);
        checkOutput("clip_start", 32'(start), 32'd1);
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        repeat (64) tick();
        checkOutput("clip_last_valid", 32'(m_valid), 32'd1);
        checkOutput("clip_last_flag",  32'(m_last),  32'd1);
        checkOutput("clip_last_data",  m_data,       32'h0000_019C);
        tick();
        checkOutput("clip_job_done", 32'(job_done), 32'd1);
        expStarts++;
        expDones++;
        tick();

`ifdef CONV_TIMEOUT_EN
        // Watchdog: done never arrives; err and job_done 16 cycles into WAIT.
        $display("[TB] WAIT timeout");
        m_ready = 1'b0;
        applyStimulus(7'd0, 7'd2);
        checkOutput("tmo_start", 32'(start), 32'd1);
        tick();
        repeat (15) tick();
        checkOutput("tmo_err_early",  32'(err),  32'd0);
        checkOutput("tmo_busy_early", 32'(busy), 32'd1);
        tick();
        checkOutput("tmo_err",      32'(err),      32'd1);
        checkOutput("tmo_job_done", 32'(job_done), 32'd1);
        checkOutput("tmo_busy",     32'(busy),     32'd0);
        tick();
        checkOutput("tmo_err_sticky", 32'(err), 32'd1);
        applyStimulus(7'd0, 7'd0);
        checkOutput("tmo_err_cleared", 32'(err), 32'd0);
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        checkOutput("tmo_next_done", 32'(job_done), 32'd1);
        expStarts += 2;
        expDones  += 2;
        tick();
`else
        checkOutput("err_tied_low", 32'(err), 32'd0);
`endif

        tick();
        checkOutput("start_count",    32'(startCount),   32'(expStarts));
        checkOutput("job_done_count", 32'(jobDoneCount), 32'(expDones));
        checkOutput("mi_queue_empty", 32'(miQ.size()),   32'd0);
        checkOutput("out_queue_empty", 32'(outQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/conv_host_dma.md
Name: conv_host_dma

Overview:
Host-side initiator for the convolution accelerator's memory/control interface. Accepts an input image as a 32-bit valid/ready stream and writes it word by word into the accelerator input memory. It then pulses start, waits for done, and reads the output memory back out as a 32-bit valid/ready stream with a last marker. It sits between the system stream fabric and the conv core.

Parameters:
DSIZE, 256, byte capacity of the accelerator DI/DO memories
AW, $clog2(DSIZE), byte-address width driven to the accelerator
CW, $clog2(DSIZE)-1, word-count width (holds 0..DSIZE/4)
TIMEOUT_CYCLES, 65535, watchdog limit in WAIT (used only with CONV_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
cmd_go  in  1  one-cycle request to run a job; sampled only in IDLE
cfg_in_words  in  CW  number of 32-bit words to load
cfg_out_words  in  CW  number of 32-bit words to read back
s_data  in  32  input image word, byte 0 in bits [7:0]
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
mi_addr  out  AW  accelerator input byte address (word aligned)
mi_data  out  32  accelerator input write data
mi_wr  out  1  accelerator input write strobe
start  out  1  accelerator start pulse
done  in  1  accelerator completion (level, combinational from core)
mo_addr  out  AW  accelerator output byte address (word aligned)
mo_data  in  32  accelerator output read data (combinational on mo_addr)
m_data  out  32  output word
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_last  out  1  marks final output word
busy  out  1  high whenever state != IDLE
job_done  out  1  one-cycle pulse when job completes
err  out  1  sticky timeout error

Behaviour:
- Reset: state=IDLE; all outputs 0 (mi_addr, mo_addr, mi_data, m_data, mi_wr, start, m_valid, m_last, s_ready, busy, job_done, err). Reset mid-job aborts immediately; no partial-state recovery.
- FSM states: IDLE, LOAD, KICK, WAIT, DRAIN.
- IDLE: on cmd_go, latch cfg_in_words and cfg_out_words; clear err; zero both address counters. Go to LOAD, or to KICK if in_words==0.
- LOAD: s_ready=1 combinationally while in LOAD. On each handshake, next cycle drives mi_wr=1, mi_data=word, mi_addr=word_index*4 (registered, 1-cycle latency). The counter increments per beat. After the beat with index in_words-1, go to KICK; s_ready drops in the same cycle.
- KICK: start=1 for exactly one cycle (also the cycle of the last mi_wr), then WAIT. The core's start reset guarantees restart of its counters.
- WAIT: stay until done=1 is sampled; then go to DRAIN, or to IDLE with job_done if out_words==0. done asserted in KICK is ignored.
- DRAIN: mo_addr = rd_idx*4.
  - When !m_valid || m_ready: capture m_data<=mo_data, m_valid<=1, m_last<=(rd_idx==out_words-1), rd_idx++.
  - When the final word is handshaken: m_valid=0, m_last=0, job_done pulse, go to IDLE.
  - Full throughput: one word per cycle under continuous m_ready.
  - m_data, m_valid and m_last hold stable while m_valid&&!m_ready.
- Counts above DSIZE/4 are clipped to DSIZE/4. Address arithmetic is modulo 2^AW.
- cmd_go outside IDLE is ignored.
- busy = (state!=IDLE).

Optional Feature:
CONV_TIMEOUT_EN
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without done, the block sets err=1 (sticky until next accepted cmd_go), pulses job_done, and returns to IDLE. No DRAIN occurs.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Decomposition:
- Shared package conv_pkg: state encoding localparams (IDLE, LOAD, KICK, WAIT, DRAIN), word-to-byte shift constant (2), and DSIZE default shared with the core.
- One natural sub-module: conv_dma_skid, the 1-entry output register stage for m_data/m_valid/m_last.
- The FSM and counters stay in the top module.

Test Plan:
- Basic job: in_words=4, s_data=0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D back to back. Expect mi_wr at mi_addr 0,4,8,12 with those data. start pulses once in the cycle after the 4th handshake.
- Drain with backpressure: done held, out_words=3, mo_data model = addr+0xA0. m_ready toggles 1,0,0,1,1. Expect words 0xA0,0xA4,0xA8 in order, stable while stalled, m_last only on 0xA8, job_done 1 cycle after the last handshake.
- Zero counts: in_words=0, out_words=0. Expect no mi_wr; start 1 cycle after cmd_go; job_done on the cycle after done; m_valid never high.
- Reset mid-LOAD: assert rst_n=0 after 2 of 8 words. Expect all outputs 0 asynchronously, busy=0. A new job then starts at mi_addr 0.
- Timeout (CONV_TIMEOUT_EN, TIMEOUT_CYCLES=16): done never asserted. Expect err=1 and job_done 16 cycles after entering WAIT. The next cmd_go clears err.
- cmd_go during DRAIN is ignored; job count and outputs are unchanged.
